stream_arbiter: RTL and testbench
=================================

# stream_arbiter

Round-robin scheduler that shares one 64-bit word stream sink (typically a `serdes` des port or a shared hash/PRNG input) between `N_SRC` requesters. Each requester posts a burst length. The arbiter grants one requester at a time and forwards that requester's words to the sink with the team's `isReady`/`canReceive` handshake. It counts the burst down and flags the last word. It sits between the per-engine command buffers (`cmd_buffer_unstd` outputs) and the shared datapath resource.

## Interface
- `N_SRC`, 4: number of requesters, 2..8.
- `LEN_W`, 8: burst-length width in 64-bit words.
- `W`, 64: data word width.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `req_hasAny` input N_SRC: requester i has a pending burst request.
- `req_len` input N_SRC*LEN_W: burst length of requester i, in slice [i*LEN_W +: LEN_W]. Stable while `req_hasAny[i]`.
- `req_consume` output N_SRC: one-hot. Requester i's request is accepted this cycle.
- `src_data` input N_SRC*W: word offered by requester i.
- `src_isReady` input N_SRC: requester i transfers a word this cycle. Legal only when `src_canReceive[i]`.
- `src_canReceive` output N_SRC: requester i may transfer now.
- `src_isLast` output 1: the current transfer is the last word of the burst.
- `sink_data` output W: muxed word from the granted requester.
- `sink_isReady` output 1: word transferred to the sink this cycle.
- `sink_canReceive` input 1: sink can accept a word.
- `sink_isLast` output 1: same as `src_isLast`.
- `grant_valid` output 1: a burst is in progress (state is BUSY).
- `grant_id` output clog2(N_SRC): index of the granted requester. Meaningful only when `grant_valid`.

## Operation
- Registers:
  - `state` in {IDLE, BUSY}.
  - `grant_id`.
  - `remaining`, LEN_W bits.
  - `rr_ptr`, clog2(N_SRC) bits.
- IDLE:
  - If any `req_hasAny` is set, pick the first set bit searching cyclically from `rr_ptr` upward.
  - Assert `req_consume[pick]` combinationally in the same cycle.
  - Load `grant_id = pick` and `remaining = req_len[pick]`.
  - Set `rr_ptr = pick+1`, wrapping modulo N_SRC.
  - If `req_len[pick] != 0`, go to BUSY. A zero-length burst is consumed, the pointer advances, and the state stays IDLE.
  - With no requests, nothing changes.
- BUSY:
  - `src_canReceive[grant_id] = sink_canReceive`. All other `src_canReceive` bits are 0.
  - `sink_isReady = src_isReady[grant_id] & src_canReceive[grant_id]`.
  - `sink_data = src_data[grant_id]`.
  - On each transfer, `remaining` decrements by 1.
  - `src_isLast = sink_isLast = sink_isReady & (remaining == 1)`.
  - After the last transfer, the next state is IDLE.
- `src_isReady` from non-granted requesters is ignored.
- No request is consumed while BUSY. Requests may assert or deassert at any time in either state.
- `req_consume` is never asserted while BUSY.
- `sink_data` is zero when `grant_valid = 0`.

## Timing
- Reset (`rst = 0`, asynchronous): state IDLE, `rr_ptr = 0`, `remaining = 0`, `grant_id = 0`. All outputs are 0 while reset is held and after it is released.
- Grant latency:
  - A request is seen and consumed in cycle T.
  - `grant_valid = 1` and the first transfer is possible at T+1.
- Burst end:
  - Last transfer at cycle L.
  - `grant_valid = 0` at L+1, and arbitration happens at L+1.
  - The next burst's first word can transfer at L+2.
  - There is exactly one bubble cycle between bursts.
- Backpressure: `sink_canReceive = 0` stalls `remaining` with no loss. The stall length is unbounded.
- Length range: `req_len` = 2^LEN_W − 1 is legal. The counter never wraps.
- Reset asserted mid-burst: the burst is abandoned immediately. The requester is not re-consumed.

## Structure
- Shared package `stream_arbiter_pkg`: state encoding (IDLE=0, BUSY=1) and default `W`/`LEN_W`.
- Sub-module `rr_picker`: combinational `N_SRC`-bit cyclic priority search. Inputs are the request vector and the pointer; outputs are `any` and the index.
- All flops are local, with asynchronous active-low reset. `delay` is not reused because its reset is synchronous.

## Test plan
- Reset, then `req_hasAny = 0001`, `len0 = 3`, sink always ready:
  - `req_consume = 0001` at T.
  - 3 transfers at T+1..T+3.
  - `isLast` only at T+3.
  - `grant_valid = 0` at T+4.
- All four requesters request continuously, each with len 1: grants cycle 0,1,2,3,0. Each grant is separated by one bubble cycle.
- Grant to source 2 with len 4, `sink_canReceive` toggling 1,0,0,1,1,0,1:
  - Exactly 4 `sink_isReady` pulses.
  - `remaining` holds during the stalls.
  - Data order is preserved.
- `req_len[1] = 0` with src 1 requesting, then src 1 requesting again with len 2:
  - The first request is consumed with no BUSY.
  - `rr_ptr` goes to 2.
  - The next grant goes to src 1 only if no src 2/3/0 is requesting.
- Non-granted source drives `src_isReady = 1` during another source's burst: no effect on the sink or the counter.
- `rst` low in the middle of a len-5 burst:
  - All outputs are 0 immediately.
  - After release, state is IDLE, `rr_ptr = 0`, and the next grant goes to the lowest-index requester.

Source files
------------

// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the stream arbiter.
//   arb_state_t : arbiter state encoding (IDLE = 0, BUSY = 1)
//   DEF_*       : default sizing for requester count, burst-length and word widths
package stream_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_N_SRC = 4;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_W     = 64;

endpackage

// File: rtl/rr_picker.sv
// Combinational cyclic priority search.
//   req : request vector, one bit per requester
//   ptr : index with highest priority this cycle; search wraps upward from here
//   any : at least one request is set
//   idx : first set request found at or after ptr (modulo N)
module rr_picker #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last
    // and wins; avoids a loop break.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin scheduler sharing one word-stream sink between N_SRC requesters.
// A requester posts a burst length; the winner is consumed, then its words are
// forwarded to the sink until the burst count runs out.
//   clk, rst        : clock, asynchronous active-low reset
//   req_hasAny/len  : per-requester pending burst and its length (LEN_W slices)
//   req_consume     : one-hot, request accepted this cycle (IDLE only)
//   src_data/isReady: per-requester word and transfer strobe
//   src_canReceive  : granted requester may transfer (follows sink_canReceive)
//   src_isLast      : current transfer closes the burst
//   sink_*          : muxed word stream toward the shared resource
//   grant_valid/id  : burst in progress and its owner
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter  int N_SRC = DEF_N_SRC,
    parameter  int LEN_W = DEF_LEN_W,
    parameter  int W     = DEF_W,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       req_hasAny,
    input  logic [N_SRC*LEN_W-1:0] req_len,
    output logic [N_SRC-1:0]       req_consume,
    input  logic [N_SRC*W-1:0]     src_data,
    input  logic [N_SRC-1:0]       src_isReady,
    output logic [N_SRC-1:0]       src_canReceive,
    output logic                   src_isLast,
    output logic [W-1:0]           sink_data,
    output logic                   sink_isReady,
    input  logic                   sink_canReceive,
    output logic                   sink_isLast,
    output logic                   grant_valid,
    output logic [IDX_W-1:0]       grant_id
);

    logic [N_SRC-1:0][LEN_W-1:0] lens;
    logic [N_SRC-1:0][W-1:0]     words;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gid_q, gid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [N_SRC-1:0] consume_raw;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             busy, xfer, last;

    assign lens  = req_len;
    assign words = src_data;

    rr_picker #(.N(N_SRC)) u_pick (
        .req (req_hasAny),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign busy = (state_q == BUSY);
    // Strobes from non-granted requesters never reach the sink or the counter.
    assign xfer = busy & sink_canReceive & src_isReady[gid_q];
    // remaining is never 0 while BUSY, so ==1 is the final word.
    assign last = xfer & (rem_q == LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        gid_d       = gid_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        consume_raw = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    consume_raw[pick_idx] = 1'b1;
                    gid_d = pick_idx;
                    rem_d = lens[pick_idx];
                    ptr_d = (pick_idx == IDX_W'(N_SRC - 1)) ? '0 : pick_idx + IDX_W'(1);
                    // Zero-length bursts are consumed without entering BUSY.
                    if (lens[pick_idx] != '0) state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gid_q   <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    // consume is purely combinational from the request inputs, so it must be
    // masked explicitly to stay quiet while reset is held.
    assign req_consume = rst ? consume_raw : '0;

    for (genvar i = 0; i < N_SRC; i++) begin : g_can
        assign src_canReceive[i] = busy & sink_canReceive & (gid_q == IDX_W'(i));
    end

    assign sink_data    = busy ? words[gid_q] : '0;
    assign sink_isReady = xfer;
    assign src_isLast   = last;
    assign sink_isLast  = last;
    assign grant_valid  = busy;
    assign grant_id     = gid_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: directed table, corner sequences and
// randomized traffic checked every cycle against a transaction-level model.
module tb_stream_arbiter;

    localparam int N     = 4;
    localparam int LEN_W = 8;
    localparam int W     = 64;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N-1:0]               has;
    logic [N-1:0][LEN_W-1:0]    lens;
    logic [N-1:0][W-1:0]        data;
    logic [N-1:0]               rdy;
    logic                       sink_can;

    logic [N-1:0]               req_consume;
    logic [N-1:0]               src_canReceive;
    logic                       src_isLast;
    logic [W-1:0]               sink_data;
    logic                       sink_isReady;
    logic                       sink_isLast;
    logic                       grant_valid;
    logic [1:0]                 grant_id;

    stream_arbiter #(.N_SRC(N), .LEN_W(LEN_W), .W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_hasAny      (has),
        .req_len         (lens),
        .req_consume     (req_consume),
        .src_data        (data),
        .src_isReady     (rdy),
        .src_canReceive  (src_canReceive),
        .src_isLast      (src_isLast),
        .sink_data       (sink_data),
        .sink_isReady    (sink_isReady),
        .sink_canReceive (sink_can),
        .sink_isLast     (sink_isLast),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: owner of the current burst (-1 = none), words still owed, and
    // the requester index that gets first look at the next arbitration.
    int m_owner = -1;
    int m_left  = 0;
    int m_ptr   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int model_pick();
        int c;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (has[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_model();
        logic [N-1:0] e_cons, e_can;
        logic         e_gv, e_sr, e_last;
        logic [W-1:0] e_data;
        int           p;
        e_cons = '0; e_can = '0; e_gv = 1'b0; e_sr = 1'b0; e_last = 1'b0; e_data = '0;
        if (rst) begin
            if (m_owner < 0) begin
                p = model_pick();
                if (p >= 0) e_cons[p] = 1'b1;
            end else begin
                e_gv          = 1'b1;
                e_can[m_owner] = sink_can;
                e_sr          = rdy[m_owner] & sink_can;
                e_data        = data[m_owner];
                e_last        = e_sr && (m_left == 1);
            end
        end
        chk("m_consume",  req_consume,    e_cons);
        chk("m_canrecv",  src_canReceive, e_can);
        chk("m_gvalid",   grant_valid,    e_gv);
        chk("m_sinkrdy",  sink_isReady,   e_sr);
        chk("m_sinkdata", sink_data,      e_data);
        chk("m_srclast",  src_isLast,     e_last);
        chk("m_sinklast", sink_isLast,    e_last);
        if (e_gv) chk("m_gid", grant_id, m_owner);
        if (!rst) chk("m_gid_rst", grant_id, 0);
    endtask

    task automatic model_advance();
        int p;
        if (!rst) begin
            m_owner = -1; m_left = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            p = model_pick();
            if (p >= 0) begin
                m_ptr = (p + 1) % N;
                if (lens[p] != 0) begin
                    m_owner = p;
                    m_left  = lens[p];
                end
            end
        end else if (rdy[m_owner] && sink_can) begin
            m_left--;
            if (m_left == 0) m_owner = -1;
        end
    endtask

    // Inputs are driven 1 after a rising edge; outputs are checked 3 later.
    task automatic settle();
        #3;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        cyc++;
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0; has = '0; rdy = '0; sink_can = 1'b1;
        cycle();
        rst = 1'b1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] has;
        logic [7:0]   len;
        logic         sink_can;
        logic [N-1:0] rdy;
        logic [N-1:0] e_cons;
        logic         e_gv;
        logic [1:0]   e_gid;
        logic         e_sr;
        logic         e_last;
    } vec_t;

    function automatic vec_t mk(logic r, logic [N-1:0] h, logic [7:0] l, logic s, logic [N-1:0] y,
                                logic [N-1:0] ec, logic eg, logic [1:0] ei, logic es, logic el);
        vec_t v;
        v.rst = r; v.has = h; v.len = l; v.sink_can = s; v.rdy = y;
        v.e_cons = ec; v.e_gv = eg; v.e_gid = ei; v.e_sr = es; v.e_last = el;
        return v;
    endfunction

    vec_t vecs[$];
    int   pulses;
    bit   pat[7];

    initial begin
        rst = 1'b0; has = '0; rdy = '0; sink_can = 1'b1;
        for (int i = 0; i < N; i++) begin
            lens[i] = '0;
            data[i] = 64'hA000_0000_0000_0000 | 64'(i);
        end
        #6;

        // ---- table: single len-3 burst, then reset and a full rotation ----
        //             rst has     len sink rdy      cons    gv gid sr last
        vecs.push_back(mk(0, 4'b0001, 3, 1, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0001, 3, 1, 4'b0001, 4'b0001, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 3, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
        vecs.push_back(mk(1, 4'b0000, 3, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
        vecs.push_back(mk(1, 4'b0000, 3, 1, 4'b0001, 4'b0000, 1, 0, 1, 1));
        vecs.push_back(mk(1, 4'b0000, 3, 1, 4'b0001, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0001, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0000, 1, 0, 1, 1));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0010, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0000, 1, 1, 1, 1));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0100, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0000, 1, 2, 1, 1));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b1000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0000, 1, 3, 1, 1));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0001, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 4'b0000, 1, 0, 1, 1));
        vecs.push_back(mk(1, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; has = vecs[i].has; sink_can = vecs[i].sink_can; rdy = vecs[i].rdy;
            for (int s = 0; s < N; s++) lens[s] = vecs[i].len;
            settle();
            chk("t_consume", req_consume,  vecs[i].e_cons);
            chk("t_gvalid",  grant_valid,  vecs[i].e_gv);
            chk("t_sinkrdy", sink_isReady, vecs[i].e_sr);
            chk("t_last",    sink_isLast,  vecs[i].e_last);
            if (vecs[i].e_gv || !vecs[i].rst) chk("t_gid", grant_id, vecs[i].e_gid);
            tick();
        end

        // ---- backpressure on a len-4 burst from src 2; src 0 strobes too ----
        do_reset();
        has = 4'b0100; lens[2] = 8'd4; sink_can = 1'b1; rdy = 4'b0101; data[2] = 64'd100;
        settle();
        chk("bp_consume", req_consume, 4'b0100);
        tick();
        has = '0;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            sink_can = pat[k];
            data[2]  = 64'd100 + 64'(pulses);
            settle();
            chk("bp_gvalid", grant_valid, 1'b1);
            if (sink_isReady) begin
                chk("bp_data", sink_data, 64'd100 + 64'(pulses));
                pulses++;
            end
            tick();
        end
        chk("bp_pulses", pulses, 4);
        sink_can = 1'b1;
        settle();
        chk("bp_done", grant_valid, 1'b0);
        tick();

        // ---- zero-length burst advances the pointer without a grant ----
        do_reset();
        rdy = 4'b1111; has = 4'b0010; lens[1] = 8'd0; lens[0] = 8'd1;
        settle();
        chk("zl_consume", req_consume, 4'b0010);
        tick();
        has = '0;
        settle();
        chk("zl_nobusy", grant_valid, 1'b0);
        tick();
        has = 4'b0011; lens[1] = 8'd2;
        settle();
        chk("zl_ptr_skip", req_consume, 4'b0001);
        tick();
        cycle();
        settle();
        chk("zl_src1", req_consume, 4'b0010);
        tick();
        has = '0;
        repeat (3) cycle();

        // ---- reset in the middle of a len-5 burst ----
        do_reset();
        has = 4'b1000; lens[3] = 8'd5; rdy = 4'b1000; sink_can = 1'b1;
        cycle();
        has = '0;
        cycle();
        cycle();
        rst = 1'b0; has = 4'b0110; lens[1] = 8'd2; lens[2] = 8'd2;
        settle();
        chk("mr_gvalid",  grant_valid,    1'b0);
        chk("mr_sinkrdy", sink_isReady,   1'b0);
        chk("mr_canrecv", src_canReceive, 4'b0000);
        chk("mr_consume", req_consume,    4'b0000);
        tick();
        rst = 1'b1;
        settle();
        chk("mr_lowest", req_consume, 4'b0010);
        tick();
        has = '0; rdy = 4'b1111;
        repeat (4) cycle();

        // ---- randomized traffic ----
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                has[i] = ($urandom_range(0, 2) == 0);
                // A length may only change while its requester is idle.
                if (!has[i]) lens[i] = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
                data[i] = {$urandom, $urandom};
            end
            rdy      = 4'($urandom);
            sink_can = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
